cic_pdm_modulator: RTL and testbench
====================================

// Module: cic_pdm_modulator
// PURPOSE
//  PCM-to-PDM transmit path: 3-stage CIC interpolator (x R) feeding a 1st-order sigma-delta that emits a 1-bit PDM stream.
//  Mirror of the CIC decimator receive chain: signed PCM samples arrive at the decimated rate (one per R clk) via valid/ready.
//  The block drives a 1-bit PDM line at the full clk rate; looping it back into the decimator recovers the PCM.
// PARAMETERS
//  IN_W   16  signed two's-complement PCM sample width
//  LOG2R  6   log2 of interpolation ratio R (R = 64)
//  ACC_W  IN_W+3*LOG2R (34)  comb/integrator internal width; modular (wrap-around) arithmetic
// PORTS
//  clk        in   1     single clock; PDM bit rate
//  rst        in   1     asynchronous, active-low reset (all state cleared while rst==0)
//  in_data    in   IN_W  signed PCM sample
//  in_valid   in   1     in_data valid
//  in_ready   out  1     block can accept a sample this cycle
//  pdm_out    out  1     PDM bitstream, one bit per clk
//  sample_tick out 1     1-cycle pulse when a sample enters the comb chain (every R clk)
//  underrun   out  1     1-cycle pulse: sample_tick with no fresh sample held
// BEHAVIOUR
//  Reset: pdm_out=0, in_ready=1, sample_tick=0, underrun=0; phase cnt, holding reg, combs, integrators, DSM acc = 0.
//  Phase counter cnt: LOG2R bits, free-running 0..R-1 from reset release, wraps R-1 -> 0. tick = (cnt==R-1).
//  Holding reg: hold_data/hold_full. in_ready = !hold_full || tick. Accept = in_valid && in_ready.
//   - Accept: hold_data<=in_data, hold_full<=1.
//   - tick: hold_data consumed by combs; hold_full<=0 unless accept same cycle (then stays 1 with new data).
//   - tick with hold_full==0: combs re-consume last hold_data (sample repeat), underrun pulses that cycle.
//  sample_tick = registered tick (high cycle T+1 where T = tick cycle); underrun aligned with sample_tick.
//  Combs (3, slow rate): x0=sext(hold_data); ck = x(k-1) - d_k; d_k<=x(k-1) on tick only; comb_q<=c3 on tick.
//  Zero-stuff: integrator-1 input = comb_q on cycle T+1 only, else 0.
//  Integrators (3, every clk): i1+=stuffed; i2+=i1; i3+=i2 (registered; modular ACC_W). i3 valid at T+4 edge.
//  Scale: DC gain is exactly R^2 -> s = i3 >>> (2*LOG2R) (arithmetic); saturate to IN_W signed; registered (T+5).
//  DSM: u = s_sat + 2^(IN_W-1) (unsigned 0..2^IN_W-1); sum = acc + u (IN_W+1 bits); pdm_out<=sum[IN_W]; acc<=sum[IN_W-1:0].
//  Latency: sample consumed at tick T -> first affected pdm_out bit registered at T+6.
//  Ones density over time = u/2^IN_W; constant input x settles to s_sat==x exactly after 3*R+6 cycles.
//  rst asserted mid-stream: immediate clear of all state/outputs; restart at cnt=0 on release, no residual output.
//  in_valid held low forever: repeats last sample, underrun pulse every R cycles; output stays continuous.
// TESTING
//  1. Reset, in_data=0 held valid: in_ready low except tick cycles; after settle pdm_out alternates 0,1,0,1; no underrun.
//  2. in_data=16'sh7FFF constant: after 3R+6 cycles s_sat=32767; exactly 1 zero per 65536 pdm bits (count over 2^16).
//  3. in_data=16'sh8000 constant: pdm_out stays 0 after settle; in_data=16'sh4000 -> 3 ones per 4 bits.
//  4. Step 0 -> 16'sh4000 then loop pdm_out into CIC decimator (R=64): decoded output settles to scaled 0x4000 DC, no wrap glitch.
//  5. Stall in_valid for 3 ticks: underrun pulses exactly 3 times aligned with sample_tick; held value repeated.
//  6. Assert rst for 1 cycle mid-stream at cnt=17: all outputs 0/in_ready=1 during reset; cnt restarts at 0; first tick R-1 later.

Source files
------------

// File: rtl/cic_pdm_modulator.sv
// PCM-to-PDM transmit path: 3-stage CIC interpolator (x 2**LOG2R) feeding a
// first-order sigma-delta modulator that drives a 1-bit PDM line at clk rate.
module cic_pdm_modulator #(
  parameter int IN_W  = 16,
  parameter int LOG2R = 6,
  parameter int ACC_W = IN_W + 3 * LOG2R
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   pdm_out,
  output logic                   sample_tick,
  output logic                   underrun
);

  localparam int SW = ACC_W - 2 * LOG2R;
  localparam logic [LOG2R-1:0] CNT_LAST = {LOG2R{1'b1}};
  localparam logic [LOG2R-1:0] CNT_PRE  = {{(LOG2R-1){1'b1}}, 1'b0};
  localparam logic [LOG2R-1:0] CNT_ONE  = {{(LOG2R-1){1'b0}}, 1'b1};

  // Clamp the gain-corrected integrator output to the PCM range.
  function automatic logic [IN_W-1:0] sat_fn(input logic [SW-1:0] v);
    logic [IN_W-1:0] r;
    if ((&v[SW-1:IN_W-1]) || !(|v[SW-1:IN_W-1])) begin
      r = v[IN_W-1:0];
    end else if (v[SW-1]) begin
      r = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(IN_W-1){1'b1}}};
    end
    return r;
  endfunction

  logic [LOG2R-1:0] cnt_r;
  logic             tick_s;
  logic             accept_s;
  logic             hold_full_r;
  logic             hold_full_nxt_s;
  logic [IN_W-1:0]  hold_data_r;
  logic             in_ready_r;
  logic [ACC_W-1:0] x0_s, c1_s, c2_s, c3_s;
  logic [ACC_W-1:0] d1_r, d2_r, d3_r, comb_q_r;
  logic [ACC_W-1:0] stuff_s;
  logic [ACC_W-1:0] i1_r, i2_r, i3_r;
  logic [SW-1:0]    shifted_s;
  logic [IN_W-1:0]  s_sat_r;
  logic [IN_W-1:0]  u_s;
  logic [IN_W:0]    sum_s;
  logic [IN_W-1:0]  dsm_acc_r;

  assign tick_s   = (cnt_r == CNT_LAST);
  assign in_ready = in_ready_r;
  assign accept_s = in_valid && in_ready_r;

  // Holding register occupancy: a fresh accept wins over consumption on tick.
  always_comb begin
    hold_full_nxt_s = hold_full_r;
    if (accept_s) begin
      hold_full_nxt_s = 1'b1;
    end else if (tick_s) begin
      hold_full_nxt_s = 1'b0;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end
  end

  // Phase counter, holding register and the registered handshake/status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {LOG2R{1'b0}};
      hold_full_r <= 1'b0;
      hold_data_r <= {IN_W{1'b0}};
      in_ready_r  <= 1'b1;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt_r       <= cnt_r + CNT_ONE;
      hold_full_r <= hold_full_nxt_s;
      if (accept_s) begin
        hold_data_r <= in_data;
      end else begin
        hold_data_r <= hold_data_r;
      end
      // in_ready is precomputed for the next cycle so it leaves on a flop
      in_ready_r  <= !hold_full_nxt_s || (cnt_r == CNT_PRE);
      sample_tick <= tick_s;
      underrun    <= tick_s && !hold_full_r;
    end
  end

  assign x0_s = {{(ACC_W-IN_W){hold_data_r[IN_W-1]}}, hold_data_r};
  assign c1_s = x0_s - d1_r;
  assign c2_s = c1_s - d2_r;
  assign c3_s = c2_s - d3_r;

  // Comb delay line advances only at the slow rate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_r     <= {ACC_W{1'b0}};
      d2_r     <= {ACC_W{1'b0}};
      d3_r     <= {ACC_W{1'b0}};
      comb_q_r <= {ACC_W{1'b0}};
    end else if (tick_s) begin
      d1_r     <= x0_s;
      d2_r     <= c1_s;
      d3_r     <= c2_s;
      comb_q_r <= c3_s;
    end else begin
      d1_r     <= d1_r;
      d2_r     <= d2_r;
      d3_r     <= d3_r;
      comb_q_r <= comb_q_r;
    end
  end

  // Zero-stuffing: the comb result appears for exactly one fast cycle.
  always_comb begin
    stuff_s = {ACC_W{1'b0}};
    if (sample_tick) begin
      stuff_s = comb_q_r;
    end else begin
      stuff_s = {ACC_W{1'b0}};
    end
  end

  // Integrators run every clock; wrap-around is harmless since the net gain is bounded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_r <= {ACC_W{1'b0}};
      i2_r <= {ACC_W{1'b0}};
      i3_r <= {ACC_W{1'b0}};
    end else begin
      i1_r <= i1_r + stuff_s;
      i2_r <= i2_r + i1_r;
      i3_r <= i3_r + i2_r;
    end
  end

  // DC gain is exactly R^2, so dropping the low 2*LOG2R bits is an arithmetic shift.
  assign shifted_s = i3_r[ACC_W-1:2*LOG2R];
  assign u_s       = {~s_sat_r[IN_W-1], s_sat_r[IN_W-2:0]};
  assign sum_s     = {1'b0, dsm_acc_r} + {1'b0, u_s};

  // Scaling register and first-order sigma-delta: the carry out is the PDM bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_sat_r   <= {IN_W{1'b0}};
      dsm_acc_r <= {IN_W{1'b0}};
      pdm_out   <= 1'b0;
    end else begin
      s_sat_r   <= sat_fn(shifted_s);
      dsm_acc_r <= sum_s[IN_W-1:0];
      pdm_out   <= sum_s[IN_W];
    end
  end

endmodule

// File: tb/tb_cic_pdm_modulator.sv
// Self-checking bench for cic_pdm_modulator: a convolution-based model of the
// CIC interpolator plus an arithmetic sigma-delta predicts every output bit.
module tb_cic_pdm_modulator;
  localparam int R    = 64;
  localparam int HLEN = 3 * R - 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [15:0] in_data = 16'sd0;
  logic in_valid = 1'b0;
  logic in_ready, pdm_out, sample_tick, underrun;

  int n_cmp = 0;
  int n_bad = 0;

  // CIC impulse response: three length-R boxcars convolved together
  longint h[HLEN];

  int m_c;
  logic signed [15:0] m_hold;
  bit m_fresh;
  int m_acc;
  bit m_pdm, m_stick, m_under;
  int t_q[$];
  longint v_q[$];

  int ones_cnt;
  int under_cnt;
  int first_st;

  typedef struct {
    logic signed [15:0] data;
    int ones64;
  } vec_t;
  vec_t tbl[6];

  cic_pdm_modulator dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pdm_out(pdm_out), .sample_tick(sample_tick),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (model cycle %0d)", name, act, exp, m_c);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_hold = 16'sd0; m_fresh = 1'b0; m_acc = 0;
    m_pdm = 1'b0; m_stick = 1'b0; m_under = 1'b0;
    t_q.delete(); v_q.delete();
  endtask

  // Interpolated, gain-corrected, saturated value visible in cycle c
  function automatic longint s_of(input int c);
    longint y;
    int k;
    y = 0;
    for (int j = 0; j < t_q.size(); j++) begin
      k = c - t_q[j] - 5;
      if (k >= 0 && k < HLEN) y += v_q[j] * h[k];
    end
    y = y >>> 12;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y;
  endfunction

  // Called at a falling edge: check current outputs, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic signed [15:0] d);
    bit tick, acc_ok;
    longint s, sum;
    tick = ((m_c % R) == R - 1);
    chk("in_ready", in_ready, (!m_fresh || tick));
    chk("sample_tick", sample_tick, m_stick);
    chk("underrun", underrun, m_under);
    chk("pdm_out", pdm_out, m_pdm);
    if (pdm_out) ones_cnt++;
    if (underrun) under_cnt++;
    if (sample_tick && first_st < 0) first_st = m_c;
    in_valid = v;
    in_data  = d;
    acc_ok  = v && (!m_fresh || tick);
    m_stick = tick;
    m_under = tick && !m_fresh;
    if (tick) begin
      t_q.push_back(m_c);
      v_q.push_back(longint'(m_hold));
    end
    while (t_q.size() > 0 && t_q[0] < m_c - 2 * HLEN) begin
      t_q.pop_front();
      v_q.pop_front();
    end
    s = s_of(m_c);
    sum = longint'(m_acc) + s + 32768;
    m_pdm = (sum >= 65536);
    m_acc = int'(sum % 65536);
    if (acc_ok) begin
      m_hold = d;
      m_fresh = 1'b1;
    end else if (tick) begin
      m_fresh = 1'b0;
    end
    m_c++;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < HLEN; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c] += 1;

    tbl[0] = '{16'sh0000, 32};
    tbl[1] = '{16'sh4000, 48};
    tbl[2] = '{16'sh8000, 0};
    tbl[3] = '{16'shC000, 16};
    tbl[4] = '{16'sh2000, 40};
    tbl[5] = '{16'shE000, 24};

    model_reset();
    ones_cnt = 0; under_cnt = 0; first_st = -1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_pdm_out", pdm_out, 0);
    chk("reset_sample_tick", sample_tick, 0);
    chk("reset_underrun", underrun, 0);
    rst = 1'b1;
    model_reset();

    // constant-input density table (settle, then count ones over 64 bits)
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 270; i++) cycle(1'b1, tbl[t].data);
      ones_cnt = 0;
      for (int i = 0; i < R; i++) cycle(1'b1, tbl[t].data);
      chk($sformatf("ones64_%0d", t), ones_cnt, tbl[t].ones64);
    end

    // randomized traffic, mostly valid
    for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 3) != 0, 16'($urandom));
    // randomized traffic, sparse valid (frequent underruns)
    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 7) == 0, 16'($urandom));

    // stall: held sample consumed once, then three underrun pulses
    for (int i = 0; i < R; i++) cycle(1'b1, 16'sh4000);
    for (int i = 0; i < R && (m_c % R) != 0; i++) cycle(1'b1, 16'sh4000);
    under_cnt = 0;
    for (int i = 0; i < 4 * R + 2; i++) cycle(1'b0, 16'sh7FFF);
    chk("stall_underruns", under_cnt, 3);
    for (int i = 0; i < 2 * R; i++) cycle(1'b1, 16'sh1000);

    // asynchronous reset mid-stream at cnt == 17
    for (int i = 0; i < R && (m_c % R) != 17; i++) cycle(1'b1, 16'sh1234);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_pdm_out", pdm_out, 0);
    chk("midrst_sample_tick", sample_tick, 0);
    chk("midrst_underrun", underrun, 0);
    @(negedge clk);
    chk("midrst_hold_pdm_out", pdm_out, 0);
    rst = 1'b1;
    model_reset();
    first_st = -1;
    for (int i = 0; i < 70; i++) cycle(1'b1, 16'sh2000);
    chk("first_sample_tick_after_reset", first_st, R);

    // full scale positive: exactly one zero per 2^16 bits
    for (int i = 0; i < 270; i++) cycle(1'b1, 16'sh7FFF);
    ones_cnt = 0;
    for (int i = 0; i < 65536; i++) cycle(1'b1, 16'sh7FFF);
    chk("ones_7fff_65536", ones_cnt, 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
